s_axil_register: RTL and testbench

- AXI4-Lite slave holding a bank of NUM_REG read/write registers.
- Sits at the responder end of the AXI-Lite register interface that the team's master BFM drives.
- Write and read channels run independently and may be active at the same time.
- Register contents are also exported as a flat bus for fabric logic.

---
 rtl/s_axil_register_if.sv | 34 +++
 rtl/s_axil_register.sv | 217 +++++++++++++++++++++
 tb/tb_s_axil_register.sv | 525 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/s_axil_register_if.sv
// AXI4-Lite register bus bundle shared by the register slave and its bus master.
// The master modport drives requests; the slave modport drives ready/response.
interface s_axil_register_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   AWADDR;
    logic                    AWVALID;
    logic                    AWREADY;
    logic [DATA_WIDTH-1:0]   WDATA;
    logic [DATA_WIDTH/8-1:0] WSTRB;
    logic                    WVALID;
    logic                    WREADY;
    logic [1:0]              BRESP;
    logic                    BVALID;
    logic                    BREADY;
    logic [ADDR_WIDTH-1:0]   ARADDR;
    logic                    ARVALID;
    logic                    ARREADY;
    logic [DATA_WIDTH-1:0]   RDATA;
    logic [1:0]              RRESP;
    logic                    RVALID;
    logic                    RREADY;

    modport master (
        output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );

    modport slave (
        input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );
endinterface

// File: rtl/s_axil_register.sv
// AXI4-Lite slave exposing NUM_REG read/write registers.
// Write and read channels are independent state machines. A write is
// committed one cycle after both AW and W are held, and the response is
// raised at the same edge the register changes. All bus outputs are
// registered; the register bank is also exported flat on REG_OUT.
module s_axil_register #(
    parameter int S_AXI_DATA_WIDTH = 32,
    parameter int S_AXI_ADDR_WIDTH = 32,
    parameter int NUM_REG          = 16
) (
    input  logic                                ACLK,
    input  logic                                ARESET,
    s_axil_register_if.slave                    s_axil,
    output logic [NUM_REG*S_AXI_DATA_WIDTH-1:0] REG_OUT
);
    localparam int DW     = S_AXI_DATA_WIDTH;
    localparam int AW     = S_AXI_ADDR_WIDTH;
    localparam int STRB_W = DW / 8;
    localparam int IDX_W  = $clog2(NUM_REG);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        WR_IDLE   = 2'd0,
        WR_COMMIT = 2'd1,
        WR_RESP   = 2'd2
    } wr_state_t;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_DATA = 1'b1
    } rd_state_t;

    // Merge new data into the old word on the byte lanes whose strobe is set.
    function automatic logic [DW-1:0] apply_strobe(
        input logic [DW-1:0]     old_v,
        input logic [DW-1:0]     new_v,
        input logic [STRB_W-1:0] strb
    );
        logic [DW-1:0] res;
        res = old_v;
        for (int b = 0; b < STRB_W; b++) begin
            if (strb[b]) begin
                res[b*8 +: 8] = new_v[b*8 +: 8];
            end else begin
                res[b*8 +: 8] = old_v[b*8 +: 8];
            end
        end
        return res;
    endfunction

    // Register bank
    logic [DW-1:0]     regs_r [NUM_REG];

    // Write channel state
    wr_state_t         wr_state_r;
    logic              aw_held_r;
    logic              w_held_r;
    logic [IDX_W-1:0]  aw_idx_r;
    logic              aw_oor_r;
    logic [DW-1:0]     wdata_r;
    logic [STRB_W-1:0] wstrb_r;
    logic              awready_r;
    logic              wready_r;
    logic              bvalid_r;
    logic [1:0]        bresp_r;

    // Read channel state
    rd_state_t         rd_state_r;
    logic              arready_r;
    logic              rvalid_r;
    logic [DW-1:0]     rdata_r;
    logic [1:0]        rresp_r;

    // Address decode and handshakes
    logic              aw_hs_s;
    logic              w_hs_s;
    logic              ar_hs_s;
    logic [IDX_W-1:0]  aw_idx_s;
    logic [IDX_W-1:0]  ar_idx_s;
    logic              aw_oor_s;
    logic              ar_oor_s;
    logic              unused_addr_bits_s;

    assign aw_hs_s  = s_axil.AWVALID & awready_r;
    assign w_hs_s   = s_axil.WVALID & wready_r;
    assign ar_hs_s  = s_axil.ARVALID & arready_r;
    assign aw_idx_s = s_axil.AWADDR[IDX_W+1:2];
    assign ar_idx_s = s_axil.ARADDR[IDX_W+1:2];
    assign aw_oor_s = |s_axil.AWADDR[AW-1:IDX_W+2];
    assign ar_oor_s = |s_axil.ARADDR[AW-1:IDX_W+2];
    // Byte offset within a word carries no meaning for a register access.
    assign unused_addr_bits_s = ^{s_axil.AWADDR[1:0], s_axil.ARADDR[1:0]};

    assign s_axil.AWREADY = awready_r;
    assign s_axil.WREADY  = wready_r;
    assign s_axil.BVALID  = bvalid_r;
    assign s_axil.BRESP   = bresp_r;
    assign s_axil.ARREADY = arready_r;
    assign s_axil.RVALID  = rvalid_r;
    assign s_axil.RDATA   = rdata_r;
    assign s_axil.RRESP   = rresp_r;

    // Write FSM: collect AW and W in any order, commit, then hold the response.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_state_r <= WR_IDLE;
            aw_held_r  <= 1'b0;
            w_held_r   <= 1'b0;
            aw_idx_r   <= '0;
            aw_oor_r   <= 1'b0;
            wdata_r    <= '0;
            wstrb_r    <= '0;
            awready_r  <= 1'b0;
            wready_r   <= 1'b0;
            bvalid_r   <= 1'b0;
            bresp_r    <= RESP_OKAY;
            for (int k = 0; k < NUM_REG; k++) begin
                regs_r[k] <= '0;
            end
        end else begin
            case (wr_state_r)
                WR_IDLE: begin
                    if (aw_hs_s) begin
                        aw_idx_r  <= aw_idx_s;
                        aw_oor_r  <= aw_oor_s;
                        aw_held_r <= 1'b1;
                    end
                    if (w_hs_s) begin
                        wdata_r  <= s_axil.WDATA;
                        wstrb_r  <= s_axil.WSTRB;
                        w_held_r <= 1'b1;
                    end
                    // A channel stays not-ready from its handshake until the response completes.
                    awready_r <= ~(aw_held_r | aw_hs_s);
                    wready_r  <= ~(w_held_r | w_hs_s);
                    if (aw_held_r && w_held_r) begin
                        wr_state_r <= WR_COMMIT;
                    end
                end
                WR_COMMIT: begin
                    if (!aw_oor_r) begin
                        regs_r[aw_idx_r] <= apply_strobe(regs_r[aw_idx_r], wdata_r, wstrb_r);
                    end
                    aw_held_r  <= 1'b0;
                    w_held_r   <= 1'b0;
                    bvalid_r   <= 1'b1;
                    bresp_r    <= aw_oor_r ? RESP_SLVERR : RESP_OKAY;
                    wr_state_r <= WR_RESP;
                end
                WR_RESP: begin
                    if (s_axil.BREADY) begin
                        bvalid_r   <= 1'b0;
                        bresp_r    <= RESP_OKAY;
                        awready_r  <= 1'b1;
                        wready_r   <= 1'b1;
                        wr_state_r <= WR_IDLE;
                    end
                end
                default: begin
                    wr_state_r <= WR_IDLE;
                    aw_held_r  <= 1'b0;
                    w_held_r   <= 1'b0;
                    awready_r  <= 1'b0;
                    wready_r   <= 1'b0;
                    bvalid_r   <= 1'b0;
                end
            endcase
        end
    end

    // Read FSM: capture the addressed register on AR and hold it until RREADY.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rd_state_r <= RD_IDLE;
            arready_r  <= 1'b0;
            rvalid_r   <= 1'b0;
            rdata_r    <= '0;
            rresp_r    <= RESP_OKAY;
        end else begin
            case (rd_state_r)
                RD_IDLE: begin
                    if (ar_hs_s) begin
                        rdata_r    <= ar_oor_s ? '0 : regs_r[ar_idx_s];
                        rresp_r    <= ar_oor_s ? RESP_SLVERR : RESP_OKAY;
                        rvalid_r   <= 1'b1;
                        arready_r  <= 1'b0;
                        rd_state_r <= RD_DATA;
                    end else begin
                        arready_r  <= 1'b1;
                    end
                end
                RD_DATA: begin
                    if (s_axil.RREADY) begin
                        rvalid_r   <= 1'b0;
                        arready_r  <= 1'b1;
                        rd_state_r <= RD_IDLE;
                    end
                end
                default: begin
                    rd_state_r <= RD_IDLE;
                    arready_r  <= 1'b0;
                    rvalid_r   <= 1'b0;
                end
            endcase
        end
    end

    // Flat export of the register bank for fabric logic.
    always_comb begin
        REG_OUT = '0;
        for (int k = 0; k < NUM_REG; k++) begin
            REG_OUT[k*DW +: DW] = regs_r[k];
        end
    end
endmodule

// File: tb/tb_s_axil_register.sv
// Self-checking bench for s_axil_register: randomized traffic against a
// word-array model of the register bank, plus directed latency/hold checks.
module tb_s_axil_register;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int NR = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NR*DW-1:0] reg_out;
    int checks = 0;
    int errors = 0;
    logic [DW-1:0] model [NR];

    always #5 clk = ~clk;

    s_axil_register_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    s_axil_register #(
        .S_AXI_DATA_WIDTH(DW),
        .S_AXI_ADDR_WIDTH(AW),
        .NUM_REG(NR)
    ) dut (
        .ACLK(clk),
        .ARESET(rst),
        .s_axil(bus),
        .REG_OUT(reg_out)
    );

    // ---------------- reference model ----------------
    function automatic logic [31:0] strobe_mask(input logic [3:0] s);
        logic [31:0] m;
        m = 32'h0;
        for (int i = 0; i < 4; i++) if (s[i]) m = m | (32'hFF << (8 * i));
        return m;
    endfunction

    function automatic logic [1:0] model_write(input logic [31:0] addr, input logic [31:0] data,
                                               input logic [3:0] strb);
        logic [31:0] m;
        if (addr >= 32'(NR * 4)) return 2'b10;
        m = strobe_mask(strb);
        model[addr / 4] = (model[addr / 4] & ~m) | (data & m);
        return 2'b00;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] addr);
        if (addr >= 32'(NR * 4)) return 32'h0;
        return model[addr / 4];
    endfunction

    function automatic logic [NR*DW-1:0] model_flat();
        logic [NR*DW-1:0] f;
        for (int i = 0; i < NR; i++) f[i*DW +: DW] = model[i];
        return f;
    endfunction

    // ---------------- bus transactions (negedge aligned) ----------------
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            output logic [1:0] resp, output bit ok);
        bit aw_p, w_p, aw_f, w_f;
        int cyc;
        ok = 1'b1;
        resp = 2'b11;
        bus.AWADDR = addr; bus.WDATA = data; bus.WSTRB = strb;
        bus.AWVALID = 1'b1; bus.WVALID = 1'b1;
        aw_p = 1'b1; w_p = 1'b1; cyc = 0;
        while ((aw_p || w_p) && cyc < 50) begin
            aw_f = aw_p && bus.AWREADY;
            w_f  = w_p && bus.WREADY;
            @(negedge clk); cyc++;
            if (aw_f) begin bus.AWVALID = 1'b0; aw_p = 1'b0; end
            if (w_f)  begin bus.WVALID = 1'b0;  w_p = 1'b0;  end
        end
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
        if (aw_p || w_p) begin ok = 1'b0; return; end
        cyc = 0;
        while (!bus.BVALID && cyc < 50) begin @(negedge clk); cyc++; end
        if (!bus.BVALID) begin ok = 1'b0; return; end
        resp = bus.BRESP;
        bus.BREADY = 1'b1;
        @(negedge clk);
        bus.BREADY = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr, output logic [31:0] data,
                           output logic [1:0] resp, output bit ok);
        int cyc;
        ok = 1'b1; data = 32'h0; resp = 2'b11;
        bus.ARADDR = addr; bus.ARVALID = 1'b1; cyc = 0;
        while (!bus.ARREADY && cyc < 50) begin @(negedge clk); cyc++; end
        if (!bus.ARREADY) begin bus.ARVALID = 1'b0; ok = 1'b0; return; end
        @(negedge clk);
        bus.ARVALID = 1'b0;
        cyc = 0;
        while (!bus.RVALID && cyc < 50) begin @(negedge clk); cyc++; end
        if (!bus.RVALID) begin ok = 1'b0; return; end
        data = bus.RDATA; resp = bus.RRESP;
        bus.RREADY = 1'b1;
        @(negedge clk);
        bus.RREADY = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.AWREADY, bus.WREADY, bus.ARREADY, bus.BVALID, bus.RVALID} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 00000",
                     {bus.AWREADY, bus.WREADY, bus.ARREADY, bus.BVALID, bus.RVALID});
        end
        checks++;
        if ({bus.BRESP, bus.RRESP, bus.RDATA} !== 36'h0) begin
            errors++;
            $display("FAIL reset_data: got %h expected 0", {bus.BRESP, bus.RRESP, bus.RDATA});
        end
        checks++;
        if (reg_out !== '0) begin
            errors++;
            $display("FAIL reset_regout: got %h expected 0", reg_out);
        end
        rst = 1'b0;
        for (int i = 0; i < NR; i++) model[i] = 32'h0;
        @(negedge clk);
        checks++;
        if ({bus.AWREADY, bus.WREADY, bus.ARREADY} !== 3'b111) begin
            errors++;
            $display("FAIL reset_release_ready: got %b expected 111",
                     {bus.AWREADY, bus.WREADY, bus.ARREADY});
        end
    endtask

    task automatic test_fill();
        logic [1:0] resp, exp_resp;
        logic [31:0] d;
        bit ok;
        for (int i = 0; i < NR; i++) begin
            do_write(32'(i * 4), 32'(i + 1), 4'hF, resp, ok);
            exp_resp = model_write(32'(i * 4), 32'(i + 1), 4'hF);
            checks++;
            if (!ok || resp !== exp_resp) begin
                errors++;
                $display("FAIL fill_bresp[%0d]: got %b ok=%0d expected %b", i, resp, ok, exp_resp);
            end
        end
        for (int i = 0; i < NR; i++) begin
            do_read(32'(i * 4), d, resp, ok);
            checks++;
            if (!ok || d !== model_read(32'(i * 4)) || resp !== 2'b00) begin
                errors++;
                $display("FAIL fill_read[%0d]: got %h/%b ok=%0d expected %h/00", i, d, resp, ok,
                         model_read(32'(i * 4)));
            end
        end
        checks++;
        if (reg_out[3*DW +: DW] !== 32'd4) begin
            errors++;
            $display("FAIL fill_regout3: got %h expected 00000004", reg_out[3*DW +: DW]);
        end
        checks++;
        if (reg_out !== model_flat()) begin
            errors++;
            $display("FAIL fill_regout_all: got %h expected %h", reg_out, model_flat());
        end
    endtask

    // order 0: AW first, 1: W first, 2: same cycle. Target register 0x10.
    task automatic split_write(input int order, input int gap, input logic [31:0] data);
        logic [31:0] old_v;
        logic [2:0] exp_idle;
        logic [1:0] r;
        old_v = model[4];
        bus.AWADDR = 32'h10; bus.WDATA = data; bus.WSTRB = 4'hF;
        if (order == 2) begin
            bus.AWVALID = 1'b1; bus.WVALID = 1'b1;
        end else begin
            if (order == 0) bus.AWVALID = 1'b1;
            else            bus.WVALID = 1'b1;
            @(negedge clk);
            bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
            exp_idle = (order == 0) ? 3'b010 : 3'b100;
            for (int c = 0; c < gap; c++) begin
                checks++;
                if ({bus.AWREADY, bus.WREADY, bus.BVALID} !== exp_idle) begin
                    errors++;
                    $display("FAIL split%0d_wait_ready c%0d: got %b expected %b", order, c,
                             {bus.AWREADY, bus.WREADY, bus.BVALID}, exp_idle);
                end
                @(negedge clk);
            end
            if (order == 0) bus.WVALID = 1'b1;
            else            bus.AWVALID = 1'b1;
        end
        @(negedge clk);                  // last handshake at edge N
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
        for (int c = 0; c < 2; c++) begin // after N and after N+1
            checks++;
            if (bus.BVALID !== 1'b0 || reg_out[4*DW +: DW] !== old_v ||
                {bus.AWREADY, bus.WREADY} !== 2'b00) begin
                errors++;
                $display("FAIL split%0d_early c%0d: bvalid=%b reg=%h rdy=%b expected 0/%h/00", order, c,
                         bus.BVALID, reg_out[4*DW +: DW], {bus.AWREADY, bus.WREADY}, old_v);
            end
            @(negedge clk);
        end
        r = model_write(32'h10, data, 4'hF);
        checks++;
        if (bus.BVALID !== 1'b1 || bus.BRESP !== r || reg_out[4*DW +: DW] !== model[4]) begin
            errors++;
            $display("FAIL split%0d_commit: bvalid=%b bresp=%b reg=%h expected 1/%b/%h", order,
                     bus.BVALID, bus.BRESP, reg_out[4*DW +: DW], r, model[4]);
        end
        bus.BREADY = 1'b1;
        @(negedge clk);
        bus.BREADY = 1'b0;
        checks++;
        if ({bus.BVALID, bus.AWREADY, bus.WREADY} !== 3'b011) begin
            errors++;
            $display("FAIL split%0d_done: got %b expected 011", order,
                     {bus.BVALID, bus.AWREADY, bus.WREADY});
        end
    endtask

    task automatic test_split();
        split_write(0, 7, 32'hA5A5A5A5);
        split_write(1, 7, $urandom);
        split_write(2, 0, $urandom);
    endtask

    task automatic test_strobe();
        logic [1:0] resp, er;
        logic [31:0] d, a, wd;
        logic [3:0] s;
        bit ok;
        do_write(32'h08, 32'h11223344, 4'hF, resp, ok);
        er = model_write(32'h08, 32'h11223344, 4'hF);
        do_write(32'h08, 32'hAABBCCDD, 4'b0101, resp, ok);
        er = model_write(32'h08, 32'hAABBCCDD, 4'b0101);
        do_read(32'h08, d, resp, ok);
        checks++;
        if (!ok || d !== 32'h11BB33DD || resp !== 2'b00) begin
            errors++;
            $display("FAIL strobe_0101: got %h/%b expected 11bb33dd/00", d, resp);
        end
        for (int i = 0; i < 8; i++) begin
            a = 32'($urandom_range(0, NR - 1) * 4) | 32'($urandom_range(0, 3));
            wd = $urandom;
            s = 4'($urandom_range(0, 15));
            if (i == 0) s = 4'h0;
            do_write(a, wd, s, resp, ok);
            er = model_write(a, wd, s);
            do_read(a, d, resp, ok);
            checks++;
            if (!ok || d !== model_read(a) || resp !== er) begin
                errors++;
                $display("FAIL strobe_rand[%0d] a=%h s=%b: got %h/%b expected %h/%b", i, a, s, d,
                         resp, model_read(a), er);
            end
        end
    endtask

    task automatic test_hold();
        logic [1:0] b0, er;
        logic [31:0] a, wd, exp_d;
        int cyc;
        a = 32'($urandom_range(0, NR - 1) * 4);
        wd = $urandom;
        bus.AWADDR = a; bus.WDATA = wd; bus.WSTRB = 4'hF;
        bus.AWVALID = 1'b1; bus.WVALID = 1'b1;
        @(negedge clk);
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
        cyc = 0;
        while (!bus.BVALID && cyc < 20) begin @(negedge clk); cyc++; end
        er = model_write(a, wd, 4'hF);
        b0 = bus.BRESP;
        checks++;
        if (bus.BVALID !== 1'b1 || b0 !== er) begin
            errors++;
            $display("FAIL hold_bvalid: got %b/%b expected 1/%b", bus.BVALID, b0, er);
        end
        bus.AWADDR = 32'h0; bus.AWVALID = 1'b1; bus.WVALID = 1'b1;
        for (int c = 0; c < 7; c++) begin
            checks++;
            if (bus.BVALID !== 1'b1 || bus.BRESP !== b0 || {bus.AWREADY, bus.WREADY} !== 2'b00) begin
                errors++;
                $display("FAIL hold_b c%0d: bvalid=%b bresp=%b rdy=%b expected 1/%b/00", c,
                         bus.BVALID, bus.BRESP, {bus.AWREADY, bus.WREADY}, b0);
            end
            @(negedge clk);
        end
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.BREADY = 1'b1;
        @(negedge clk);
        bus.BREADY = 1'b0;
        checks++;
        if (bus.BVALID !== 1'b0 || reg_out !== model_flat()) begin
            errors++;
            $display("FAIL hold_b_release: bvalid=%b regs=%h expected 0/%h", bus.BVALID, reg_out,
                     model_flat());
        end
        a = 32'($urandom_range(0, NR - 1) * 4);
        exp_d = model_read(a);
        bus.ARADDR = a; bus.ARVALID = 1'b1;
        @(negedge clk);
        bus.ARADDR = a ^ 32'h4;          // a different request waiting during the hold
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (bus.RVALID !== 1'b1 || bus.RDATA !== exp_d || bus.RRESP !== 2'b00 ||
                bus.ARREADY !== 1'b0) begin
                errors++;
                $display("FAIL hold_r c%0d: rvalid=%b rdata=%h rresp=%b arready=%b expected 1/%h/00/0",
                         c, bus.RVALID, bus.RDATA, bus.RRESP, bus.ARREADY, exp_d);
            end
            @(negedge clk);
        end
        bus.ARVALID = 1'b0; bus.RREADY = 1'b1;
        @(negedge clk);
        bus.RREADY = 1'b0;
        checks++;
        if ({bus.RVALID, bus.ARREADY} !== 2'b01) begin
            errors++;
            $display("FAIL hold_r_release: got %b expected 01", {bus.RVALID, bus.ARREADY});
        end
    endtask

    task automatic test_out_of_range();
        logic [1:0] resp, er;
        logic [31:0] d, wd;
        bit ok;
        wd = $urandom;
        do_write(32'h40, wd, 4'hF, resp, ok);
        er = model_write(32'h40, wd, 4'hF);
        checks++;
        if (!ok || resp !== 2'b10 || er !== 2'b10) begin
            errors++;
            $display("FAIL oor_write_bresp: got %b ok=%0d expected 10", resp, ok);
        end
        checks++;
        if (reg_out !== model_flat()) begin
            errors++;
            $display("FAIL oor_write_regs: got %h expected %h", reg_out, model_flat());
        end
        do_read(32'h1000, d, resp, ok);
        checks++;
        if (!ok || d !== 32'h0 || resp !== 2'b10) begin
            errors++;
            $display("FAIL oor_read_1000: got %h/%b expected 00000000/10", d, resp);
        end
        do_read(32'h80000000, d, resp, ok);
        checks++;
        if (!ok || d !== 32'h0 || resp !== 2'b10) begin
            errors++;
            $display("FAIL oor_read_msb: got %h/%b expected 00000000/10", d, resp);
        end
        wd = $urandom;
        do_write(32'h3F, wd, 4'hF, resp, ok);
        er = model_write(32'h3F, wd, 4'hF);
        do_read(32'h3D, d, resp, ok);
        checks++;
        if (!ok || d !== model[15] || resp !== er) begin
            errors++;
            $display("FAIL top_reg_lowbits: got %h/%b expected %h/%b", d, resp, model[15], er);
        end
    endtask

    task automatic test_collision();
        logic [31:0] old_v, wd, d;
        logic [1:0] er, resp;
        bit ok;
        old_v = model[5];
        wd = ~old_v ^ $urandom;
        bus.AWADDR = 32'h14; bus.WDATA = wd; bus.WSTRB = 4'hF;
        bus.AWVALID = 1'b1; bus.WVALID = 1'b1;
        @(negedge clk);                  // handshake edge N
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
        @(negedge clk);                  // after N+1
        bus.ARADDR = 32'h14; bus.ARVALID = 1'b1;
        @(negedge clk);                  // AR captured at commit edge N+2
        bus.ARVALID = 1'b0;
        checks++;
        if (bus.RVALID !== 1'b1 || bus.RDATA !== old_v || bus.BVALID !== 1'b1) begin
            errors++;
            $display("FAIL collision_old: rvalid=%b rdata=%h bvalid=%b expected 1/%h/1", bus.RVALID,
                     bus.RDATA, bus.BVALID, old_v);
        end
        er = model_write(32'h14, wd, 4'hF);
        bus.BREADY = 1'b1; bus.RREADY = 1'b1;
        @(negedge clk);
        bus.BREADY = 1'b0; bus.RREADY = 1'b0;
        do_read(32'h14, d, resp, ok);
        checks++;
        if (!ok || d !== model[5] || resp !== er) begin
            errors++;
            $display("FAIL collision_new: got %h/%b expected %h/%b", d, resp, model[5], er);
        end
    endtask

    task automatic test_concurrent();
        fork
            begin
                logic [31:0] a, wd;
                logic [3:0] s;
                logic [1:0] resp, er;
                bit ok;
                for (int i = 0; i < 10; i++) begin
                    a = 32'($urandom_range(0, 7) * 4);
                    wd = $urandom;
                    s = 4'($urandom_range(0, 15));
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    do_write(a, wd, s, resp, ok);
                    er = model_write(a, wd, s);
                    checks++;
                    if (!ok || resp !== er) begin
                        errors++;
                        $display("FAIL conc_write[%0d]: got %b ok=%0d expected %b", i, resp, ok, er);
                    end
                end
            end
            begin
                logic [31:0] a, d;
                logic [1:0] resp;
                bit ok;
                for (int j = 0; j < 10; j++) begin
                    a = 32'($urandom_range(8, 15) * 4);
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    do_read(a, d, resp, ok);
                    checks++;
                    if (!ok || d !== model_read(a) || resp !== 2'b00) begin
                        errors++;
                        $display("FAIL conc_read[%0d] a=%h: got %h/%b expected %h/00", j, a, d, resp,
                                 model_read(a));
                    end
                end
            end
        join
        checks++;
        if (reg_out !== model_flat()) begin
            errors++;
            $display("FAIL conc_regs: got %h expected %h", reg_out, model_flat());
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d, wd;
        logic [1:0] resp, er;
        bit ok;
        int cyc;
        bus.AWADDR = 32'h0; bus.AWVALID = 1'b1;      // AW only, W never comes
        @(negedge clk);
        bus.AWVALID = 1'b0;
        bus.ARADDR = 32'h20; bus.ARVALID = 1'b1;     // read left waiting on RREADY
        @(negedge clk);
        bus.ARVALID = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.AWREADY, bus.WREADY, bus.ARREADY, bus.BVALID, bus.RVALID, bus.BRESP, bus.RRESP} !== 9'b0 ||
            bus.RDATA !== 32'h0 || reg_out !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: ctrl=%b rdata=%h regs=%h expected all 0",
                     {bus.AWREADY, bus.WREADY, bus.ARREADY, bus.BVALID, bus.RVALID, bus.BRESP, bus.RRESP},
                     bus.RDATA, reg_out);
        end
        rst = 1'b0;
        for (int i = 0; i < NR; i++) model[i] = 32'h0;
        @(negedge clk);
        // W alone must not complete the write whose AW was dropped by reset.
        wd = $urandom;
        bus.WDATA = wd; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
        @(negedge clk);
        bus.WVALID = 1'b0;
        cyc = 0;
        repeat (4) begin
            if (bus.BVALID) cyc++;
            @(negedge clk);
        end
        checks++;
        if (cyc != 0 || bus.RVALID !== 1'b0) begin
            errors++;
            $display("FAIL midreset_no_response: bvalid_cycles=%0d rvalid=%b expected 0/0", cyc,
                     bus.RVALID);
        end
        bus.AWADDR = 32'h0C; bus.AWVALID = 1'b1;
        cyc = 0;
        while (!bus.BVALID && cyc < 20) begin
            @(negedge clk); cyc++;
            bus.AWVALID = 1'b0;
        end
        er = model_write(32'h0C, wd, 4'hF);
        checks++;
        if (bus.BVALID !== 1'b1 || bus.BRESP !== er) begin
            errors++;
            $display("FAIL midreset_late_aw: got %b/%b expected 1/%b", bus.BVALID, bus.BRESP, er);
        end
        bus.BREADY = 1'b1;
        @(negedge clk);
        bus.BREADY = 1'b0;
        for (int i = 0; i < NR; i++) begin
            do_read(32'(i * 4), d, resp, ok);
            checks++;
            if (!ok || d !== model[i] || resp !== 2'b00) begin
                errors++;
                $display("FAIL midreset_read[%0d]: got %h/%b expected %h/00", i, d, resp, model[i]);
            end
        end
    endtask

    initial begin
        bus.AWADDR = 32'h0; bus.AWVALID = 1'b0; bus.WDATA = 32'h0; bus.WSTRB = 4'h0;
        bus.WVALID = 1'b0; bus.BREADY = 1'b0; bus.ARADDR = 32'h0; bus.ARVALID = 1'b0;
        bus.RREADY = 1'b0;
        test_reset();
        test_fill();
        test_split();
        test_strobe();
        test_hold();
        test_out_of_range();
        test_collision();
        test_concurrent();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
